// File: rtl/bip_defs.sv
// -----------------------------------------------------------------------------
// bip_defs
// Shared definitions for the BIP accumulator CPU run-control logic.
//   - Opcode encodings. The instruction decoder uses the same table.
//   - Run-control state encodings. The encoding is binary and registered.
//   - A small helper that reports whether a state enables the datapath.
// -----------------------------------------------------------------------------
package bip_defs;

    localparam int NB_OPCODE_DEF = 5;

    // Opcode table. Any value outside this table executes as a plain
    // instruction: the controller counts it and does not halt on it.
    localparam logic [NB_OPCODE_DEF-1:0] OP_HALT  = 5'b00000;
    localparam logic [NB_OPCODE_DEF-1:0] OP_STORE = 5'b00001;
    localparam logic [NB_OPCODE_DEF-1:0] OP_LOAD  = 5'b00010;
    localparam logic [NB_OPCODE_DEF-1:0] OP_LOADI = 5'b00011;
    localparam logic [NB_OPCODE_DEF-1:0] OP_ADD   = 5'b00100;
    localparam logic [NB_OPCODE_DEF-1:0] OP_ADDI  = 5'b00101;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SUB   = 5'b00110;
    localparam logic [NB_OPCODE_DEF-1:0] OP_SUBI  = 5'b00111;

    // CLEARING is a separate state value. It lasts exactly one cycle,
    // between HALTED and IDLE.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RUN       = 3'd1,
        ST_STEP_WAIT = 3'd2,
        ST_STEP_EXEC = 3'd3,
        ST_HALTED    = 3'd4,
        ST_CLEARING  = 3'd5
    } state_t;

    // The datapath advances only in the states that execute an instruction.
    function automatic logic is_exec_state(input state_t s);
        return (s == ST_RUN) || (s == ST_STEP_EXEC);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
// Up-counter that saturates at all-ones and never wraps.
//   i_clock  : clock, rising edge
//   i_reset  : synchronous active-high reset to zero
//   i_clear  : synchronous clear to zero. It takes priority over i_inc.
//   i_inc    : add one this cycle, unless already saturated
//   o_count  : current count
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int NB = 16
) (
    input  logic          i_clock,
    input  logic          i_reset,
    input  logic          i_clear,
    input  logic          i_inc,
    output logic [NB-1:0] o_count
);

    logic [NB-1:0] count_reg;
    logic [NB-1:0] count_next;
    logic          at_max;

    assign at_max = &count_reg;

    always_comb begin
        count_next = count_reg;
        if (i_clear) begin
            count_next = '0;
        end else if (i_inc && !at_max) begin
            count_next = count_reg + 1'b1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

    assign o_count = count_reg;

endmodule

// File: rtl/bip_exec_controller.sv
// -----------------------------------------------------------------------------
// bip_exec_controller
// Run-control sequencer for the single-cycle BIP accumulator CPU. It gates the
// CPU-wide enable, so the program runs free or one instruction per step. It
// stops on the HALT opcode or on an abort, and it keeps the cycle and
// instruction counters for the debug unit.
//
// Ports:
//   i_clock        : clock, rising edge
//   i_reset        : synchronous active-high reset
//   i_start        : pulse. Starts execution from IDLE.
//   i_mode_step    : sampled with i_start. 1 = step mode, 0 = run mode.
//   i_step         : pulse. Executes one instruction, in STEP_WAIT only.
//   i_abort        : pulse. Stops from RUN, STEP_WAIT or STEP_EXEC.
//   i_clear        : pulse. From HALTED, clears the CPU and returns to IDLE.
//   i_opcode       : opcode of the instruction at the current PC
//   o_cpu_enb      : datapath enable (PC and accumulator write enables)
//   o_cpu_clear    : one-cycle synchronous clear of the PC and accumulator
//   o_running      : high in RUN, STEP_WAIT and STEP_EXEC
//   o_halted       : high in HALTED
//   o_cycle_count  : enabled cycles since the last clear, HALT cycle included
//   o_instr_count  : retired non-HALT instructions since the last clear
// -----------------------------------------------------------------------------
module bip_exec_controller
    import bip_defs::*;
#(
    parameter int NB_OPCODE = 5,
    parameter int NB_COUNT  = 16
) (
    input  logic                 i_clock,
    input  logic                 i_reset,
    input  logic                 i_start,
    input  logic                 i_mode_step,
    input  logic                 i_step,
    input  logic                 i_abort,
    input  logic                 i_clear,
    input  logic [NB_OPCODE-1:0] i_opcode,
    output logic                 o_cpu_enb,
    output logic                 o_cpu_clear,
    output logic                 o_running,
    output logic                 o_halted,
    output logic [NB_COUNT-1:0]  o_cycle_count,
    output logic [NB_COUNT-1:0]  o_instr_count
);

    localparam logic [NB_OPCODE-1:0] HALT_CODE = NB_OPCODE'(OP_HALT);

    state_t state_reg;
    state_t state_next;
    logic   is_halt_op;
    logic   exec_cycle;
    logic   cnt_clear;

    assign is_halt_op = (i_opcode == HALT_CODE);

    // State register
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. An abort outranks a HALT opcode, and a HALT opcode
    // outranks step and start. A step pulse that arrives outside STEP_WAIT
    // is dropped, not queued.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: begin
                if (i_start) begin
                    state_next = i_mode_step ? ST_STEP_WAIT : ST_RUN;
                end
            end
            ST_RUN: begin
                if (i_abort || is_halt_op) begin
                    state_next = ST_HALTED;
                end
            end
            ST_STEP_WAIT: begin
                if (i_abort) begin
                    state_next = ST_HALTED;
                end else if (i_step) begin
                    state_next = ST_STEP_EXEC;
                end
            end
            ST_STEP_EXEC: begin
                if (i_abort || is_halt_op) begin
                    state_next = ST_HALTED;
                end else begin
                    state_next = ST_STEP_WAIT;
                end
            end
            ST_HALTED: begin
                if (i_clear) begin
                    state_next = ST_CLEARING;
                end
            end
            ST_CLEARING: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Moore outputs, decoded from the registered state only
    always_comb begin
        exec_cycle  = is_exec_state(state_reg);
        o_cpu_enb   = exec_cycle;
        o_cpu_clear = (state_reg == ST_CLEARING);
        o_running   = (state_reg == ST_RUN) || (state_reg == ST_STEP_WAIT) ||
                      (state_reg == ST_STEP_EXEC);
        o_halted    = (state_reg == ST_HALTED);
    end

    // Clear the counters on the edge that enters CLEARING, so they already
    // read zero while o_cpu_clear is high. Holding the clear through
    // CLEARING keeps them at zero into IDLE.
    assign cnt_clear = ((state_reg == ST_HALTED) && i_clear) ||
                       (state_reg == ST_CLEARING);

    sat_counter #(
        .NB (NB_COUNT)
    ) u_cycle_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (cnt_clear),
        .i_inc   (exec_cycle),
        .o_count (o_cycle_count)
    );

    sat_counter #(
        .NB (NB_COUNT)
    ) u_instr_counter (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_clear (cnt_clear),
        .i_inc   (exec_cycle && !is_halt_op),
        .o_count (o_instr_count)
    );

endmodule

// File: tb/tb_bip_exec_controller.sv
// -----------------------------------------------------------------------------
// tb_bip_exec_controller
// Bench for bip_exec_controller. A small PC model stands in for the datapath:
// it advances on o_cpu_enb and feeds i_opcode from a program table. Each
// enabled cycle that a test expects goes into a queue, together with the
// counter values the test expects during that cycle. A negedge monitor pops
// the queue on every enabled cycle.
// -----------------------------------------------------------------------------
module tb_bip_exec_controller;

    localparam logic [4:0] HALT  = 5'b00000;
    localparam logic [4:0] LOADI = 5'b00011;
    localparam logic [4:0] ADD   = 5'b00100;
    localparam logic [4:0] ADDI  = 5'b00101;
    localparam logic [4:0] SUBI  = 5'b00111;

    logic        clk = 1'b0;
    logic        rst, start, mode_step, step, abort, clear;
    logic [4:0]  opcode;
    logic        cpu_enb, cpu_clear, running, halted;
    logic [15:0] cycle_count, instr_count;

    // Second instance with a 3-bit counter width, for the saturation test
    logic        start3, abort3;
    logic [4:0]  opcode3;
    logic        cpu_enb3, cpu_clear3, running3, halted3;
    logic [2:0]  cycle_count3, instr_count3;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] cyc;
        logic [15:0] ins;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    logic [4:0] prog [0:15];
    logic [3:0] pc;
    logic [3:0] pc_last;

    always #5 clk = ~clk;

    bip_exec_controller #(.NB_OPCODE(5), .NB_COUNT(16)) dut (
        .i_clock(clk), .i_reset(rst), .i_start(start), .i_mode_step(mode_step),
        .i_step(step), .i_abort(abort), .i_clear(clear), .i_opcode(opcode),
        .o_cpu_enb(cpu_enb), .o_cpu_clear(cpu_clear), .o_running(running),
        .o_halted(halted), .o_cycle_count(cycle_count), .o_instr_count(instr_count)
    );

    bip_exec_controller #(.NB_OPCODE(5), .NB_COUNT(3)) dut3 (
        .i_clock(clk), .i_reset(rst), .i_start(start3), .i_mode_step(1'b0),
        .i_step(1'b0), .i_abort(abort3), .i_clear(1'b0), .i_opcode(opcode3),
        .o_cpu_enb(cpu_enb3), .o_cpu_clear(cpu_clear3), .o_running(running3),
        .o_halted(halted3), .o_cycle_count(cycle_count3), .o_instr_count(instr_count3)
    );

    // Datapath stand-in. The PC advances on enable and clears on
    // reset or o_cpu_clear.
    always @(posedge clk) begin
        if (rst || cpu_clear) pc <= '0;
        else if (cpu_enb)     pc <= (pc == pc_last) ? 4'd0 : pc + 4'd1;
    end
    assign opcode  = prog[pc];
    assign opcode3 = ADD;

    // Scoreboard monitor: every enabled cycle must match a queued expectation
    always @(negedge clk) begin
        if (cpu_enb === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_enable: o_cpu_enb=1 required 0 (cycle_count=%0d)", cycle_count);
            end else begin
                mon_e = exp_q.pop_front();
                if (cycle_count !== mon_e.cyc || instr_count !== mon_e.ins) begin
                    errors++;
                    $display("FAIL enable_counts: cycle=%0d instr=%0d required cycle=%0d instr=%0d",
                             cycle_count, instr_count, mon_e.cyc, mon_e.ins);
                end
            end
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 0; mode_step = 0; step = 0; abort = 0; clear = 0;
        start3 = 0; abort3 = 0;
        wait_cycles(2);
        rst = 1'b0;
    endtask

    task automatic pulse_start(input logic m);
        start = 1'b1; mode_step = m; wait_cycles(1); start = 1'b0; mode_step = 1'b0;
    endtask

    task automatic pulse_step();
        step = 1'b1; wait_cycles(1); step = 1'b0;
    endtask

    task automatic push_exp(input int n, input int c0, input int i0);
        exp_t e;
        for (int k = 0; k < n; k++) begin
            e.cyc = 16'(c0 + k);
            e.ins = 16'(i0 + k);
            exp_q.push_back(e);
        end
    endtask

    task automatic load_prog_short();
        for (int i = 0; i < 16; i++) prog[i] = HALT;
        prog[0] = LOADI; prog[1] = ADDI; prog[2] = ADD; prog[3] = HALT;
        pc_last = 4'd15;
    endtask

    task automatic load_prog_loop();
        for (int i = 0; i < 16; i++) prog[i] = (i % 2 == 0) ? ADD : SUBI;
        prog[4] = 5'h1F;   // outside the opcode table: counted, not a halt
        pc_last = 4'd9;
    endtask

    task automatic check_queue_empty(input string name);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++;
            $display("FAIL %s: %0d expected enable cycles missing, required 0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 0; mode_step = 0; step = 0; abort = 0; clear = 0;
        start3 = 0; abort3 = 0;
        load_prog_short();
        wait_cycles(2);
        checks++;
        if ({cpu_enb, cpu_clear, running, halted} !== 4'b0000 ||
            cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: enb=%b clr=%b run=%b halt=%b cyc=%0d ins=%0d required all 0",
                     cpu_enb, cpu_clear, running, halted, cycle_count, instr_count);
        end
        rst = 1'b0;
    endtask

    task automatic test_run_mode();
        do_reset();
        load_prog_short();
        push_exp(4, 0, 0);
        pulse_start(1'b0);
        checks++;
        if (cpu_enb !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL run_latency: enb=%b run=%b required 1 1", cpu_enb, running);
        end
        wait_cycles(6);
        checks++;
        if (halted !== 1'b1 || running !== 1'b0 || cycle_count !== 16'd4 || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL run_halt: halt=%b run=%b cyc=%0d ins=%0d required 1 0 4 3",
                     halted, running, cycle_count, instr_count);
        end
        check_queue_empty("run_enables");
    endtask

    task automatic test_step_mode();
        do_reset();
        load_prog_short();
        push_exp(2, 0, 0);
        pulse_start(1'b1);
        checks++;
        if (running !== 1'b1 || cpu_enb !== 1'b0) begin
            errors++;
            $display("FAIL step_wait: run=%b enb=%b required 1 0", running, cpu_enb);
        end
        wait_cycles(2);
        pulse_step();
        checks++;
        if (cpu_enb !== 1'b1) begin
            errors++;
            $display("FAIL step_exec: enb=%b required 1", cpu_enb);
        end
        wait_cycles(1);
        checks++;
        if (cpu_enb !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL step_single: enb=%b run=%b required 0 1", cpu_enb, running);
        end
        wait_cycles(3);
        pulse_step();
        wait_cycles(2);
        checks++;
        if (instr_count !== 16'd2 || cycle_count !== 16'd2 || running !== 1'b1 || halted !== 1'b0) begin
            errors++;
            $display("FAIL step_two: ins=%0d cyc=%0d run=%b halt=%b required 2 2 1 0",
                     instr_count, cycle_count, running, halted);
        end
        check_queue_empty("step_enables");
        abort = 1'b1; wait_cycles(1); abort = 1'b0;
        checks++;
        if (halted !== 1'b1 || cycle_count !== 16'd2) begin
            errors++;
            $display("FAIL step_abort: halt=%b cyc=%0d required 1 2", halted, cycle_count);
        end
    endtask

    task automatic test_abort();
        do_reset();
        load_prog_loop();
        push_exp(6, 0, 0);
        pulse_start(1'b0);
        wait_cycles(5);
        abort = 1'b1; wait_cycles(1); abort = 1'b0;
        checks++;
        if (halted !== 1'b1 || cycle_count !== 16'd6 || instr_count !== 16'd6) begin
            errors++;
            $display("FAIL abort_halt: halt=%b cyc=%0d ins=%0d required 1 6 6",
                     halted, cycle_count, instr_count);
        end
        pulse_start(1'b0);
        pulse_step();
        wait_cycles(3);
        checks++;
        if (halted !== 1'b1 || running !== 1'b0 || cycle_count !== 16'd6) begin
            errors++;
            $display("FAIL halted_ignore: halt=%b run=%b cyc=%0d required 1 0 6",
                     halted, running, cycle_count);
        end
        check_queue_empty("abort_enables");
    endtask

    task automatic test_clear();
        clear = 1'b1; wait_cycles(1); clear = 1'b0;
        checks++;
        if (cpu_clear !== 1'b1 || cycle_count !== 16'd0 || instr_count !== 16'd0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL clearing: clr=%b cyc=%0d ins=%0d halt=%b required 1 0 0 0",
                     cpu_clear, cycle_count, instr_count, halted);
        end
        load_prog_short();
        wait_cycles(1);
        checks++;
        if ({cpu_clear, running, halted, cpu_enb} !== 4'b0000 || cycle_count !== 16'd0) begin
            errors++;
            $display("FAIL clear_idle: clr=%b run=%b halt=%b enb=%b cyc=%0d required 0 0 0 0 0",
                     cpu_clear, running, halted, cpu_enb, cycle_count);
        end
        push_exp(4, 0, 0);
        pulse_start(1'b0);
        wait_cycles(6);
        checks++;
        if (halted !== 1'b1 || cycle_count !== 16'd4 || instr_count !== 16'd3) begin
            errors++;
            $display("FAIL clear_rerun: halt=%b cyc=%0d ins=%0d required 1 4 3",
                     halted, cycle_count, instr_count);
        end
        check_queue_empty("rerun_enables");
    endtask

    task automatic test_ignored_pulses();
        do_reset();
        pulse_step();
        checks++;
        if ({running, halted, cpu_enb} !== 3'b000) begin
            errors++;
            $display("FAIL idle_step: run=%b halt=%b enb=%b required 0 0 0", running, halted, cpu_enb);
        end
        for (int i = 0; i < 16; i++) prog[i] = HALT;
        for (int i = 0; i < 8; i++) prog[i] = (i % 2 == 0) ? LOADI : ADD;
        pc_last = 4'd15;
        push_exp(9, 0, 0);
        pulse_start(1'b0);
        pulse_step();
        pulse_start(1'b1);
        checks++;
        if (running !== 1'b1 || cpu_enb !== 1'b1) begin
            errors++;
            $display("FAIL run_ignore: run=%b enb=%b required 1 1", running, cpu_enb);
        end
        wait_cycles(8);
        checks++;
        if (halted !== 1'b1 || cycle_count !== 16'd9 || instr_count !== 16'd8) begin
            errors++;
            $display("FAIL run_ignore_end: halt=%b cyc=%0d ins=%0d required 1 9 8",
                     halted, cycle_count, instr_count);
        end
        check_queue_empty("ignore_enables");
    endtask

    task automatic test_reset_mid_run();
        do_reset();
        load_prog_loop();
        push_exp(8, 0, 0);
        pulse_start(1'b0);
        wait_cycles(7);
        checks++;
        if (cycle_count !== 16'd7 || instr_count !== 16'd7) begin
            errors++;
            $display("FAIL pre_reset_counts: cyc=%0d ins=%0d required 7 7", cycle_count, instr_count);
        end
        rst = 1'b1; wait_cycles(1);
        checks++;
        if ({cpu_enb, cpu_clear, running, halted} !== 4'b0000 ||
            cycle_count !== 16'd0 || instr_count !== 16'd0) begin
            errors++;
            $display("FAIL mid_reset: enb=%b clr=%b run=%b halt=%b cyc=%0d ins=%0d required all 0",
                     cpu_enb, cpu_clear, running, halted, cycle_count, instr_count);
        end
        rst = 1'b0;
        check_queue_empty("mid_reset_enables");
    endtask

    task automatic test_saturation();
        do_reset();
        start3 = 1'b1; wait_cycles(1); start3 = 1'b0;
        wait_cycles(10);
        checks++;
        if (cycle_count3 !== 3'd7 || instr_count3 !== 3'd7 || running3 !== 1'b1) begin
            errors++;
            $display("FAIL saturate: cyc=%0d ins=%0d run=%b required 7 7 1",
                     cycle_count3, instr_count3, running3);
        end
        abort3 = 1'b1; wait_cycles(1); abort3 = 1'b0;
        checks++;
        if (halted3 !== 1'b1 || cpu_enb3 !== 1'b0 || cpu_clear3 !== 1'b0 || cycle_count3 !== 3'd7) begin
            errors++;
            $display("FAIL saturate_abort: halt=%b enb=%b clr=%b cyc=%0d required 1 0 0 7",
                     halted3, cpu_enb3, cpu_clear3, cycle_count3);
        end
    endtask

    initial begin
        test_reset();
        test_run_mode();
        test_step_mode();
        test_abort();
        test_clear();
        test_ignored_pulses();
        test_reset_mid_run();
        test_saturation();
        wait_cycles(2);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
